slicel_cfg_loader: RTL and testbench
====================================

SLICEL_CFG_LOADER -- requirements
Module: slicel_cfg_loader

Interface
REQ-001 Parameter S_XX_BASE, default 4, LUT input base (matches slice).
REQ-002 Parameter NUM_LUTS, default 4, LUTs per slice, power of 2.
REQ-003 Parameter CFG_SIZE, default 2*(2**S_XX_BASE)+1, config bits per LUT.
REQ-004 Parameter MUX_LVLS, default $clog2(NUM_LUTS), inter-LUT mux config width.
REQ-005 Derived constant FRAME_BITS = CFG_SIZE*NUM_LUTS + MUX_LVLS + 2*NUM_LUTS + 1 (143 at defaults).
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 cfg_in  input  1  serial config bit, LSB of frame first.
REQ-009 cfg_valid  input  1  cfg_in valid.
REQ-010 cfg_ready  output  1  loader accepts a beat this cycle.
REQ-011 cfg_abort  input  1  discard partial frame.
REQ-012 cfg_out  output  1  registered bit shifted out of frame[0], for daisy-chaining the next slice.
REQ-013 cfg_done  output  1  level: last frame committed.
REQ-014 luts_config_in  output  CFG_SIZE*NUM_LUTS  frame[CFG_SIZE*NUM_LUTS-1:0].
REQ-015 inter_lut_mux_config  output  MUX_LVLS  next frame field up.
REQ-016 regs_config_in  output  2*NUM_LUTS  next field up.
REQ-017 config_use_cc  output  1  frame[FRAME_BITS-1].
REQ-018 comb_set  output  1  one-cycle pulse, slice latches comb config.
REQ-019 mem_set  output  1  one-cycle pulse, slice loads register initial state.

Function
REQ-020 States: IDLE, SHIFT, COMMIT_COMB, COMMIT_MEM, DONE.
REQ-021 cfg_ready = 1 in IDLE, SHIFT, DONE; 0 in COMMIT_COMB, COMMIT_MEM; registered from state, no combinational path from inputs.
REQ-022 Beat accepted when cfg_valid && cfg_ready && !cfg_abort.
REQ-023 On accepted beat: frame <= {cfg_in, frame[FRAME_BITS-1:1]}; cfg_out <= frame[0]; bit_cnt increments.
REQ-024 After FRAME_BITS accepted beats, the first bit sent sits at frame[0].
REQ-025 IDLE or DONE + accepted beat -> SHIFT, bit_cnt = 1; cfg_done cleared same edge.
REQ-026 SHIFT + accepted beat with bit_cnt == FRAME_BITS-1 -> COMMIT_COMB, bit_cnt = 0.
REQ-027 COMMIT_COMB: comb_set = 1 exactly one cycle -> COMMIT_MEM.
REQ-028 COMMIT_MEM: mem_set = 1 exactly one cycle -> DONE.
REQ-029 DONE: cfg_done = 1 until next accepted beat or abort.
REQ-030 Latency: last beat accepted at edge N; comb_set high cycle N+1, mem_set N+2, cfg_done from N+3.
REQ-031 cfg_valid low in SHIFT: state and count hold, no timeout.
REQ-032 cfg_abort in IDLE/SHIFT/DONE -> IDLE, bit_cnt = 0, cfg_done = 0, frame contents retained, no set pulse; abort beats same-cycle valid.
REQ-033 cfg_abort ignored in COMMIT_COMB/COMMIT_MEM; commit always completes.
REQ-034 comb_set and mem_set never high simultaneously, never high outside commit states.
REQ-035 Config outputs driven directly from frame; may toggle during SHIFT, stable from COMMIT_COMB until next accepted beat.
REQ-036 bit_cnt width $clog2(FRAME_BITS+1); never exceeds FRAME_BITS-1.

Reset
REQ-037 rst asserts asynchronously: state IDLE, bit_cnt 0, frame all 0, cfg_out 0, cfg_done 0, comb_set 0, mem_set 0.
REQ-038 Reset mid-SHIFT or mid-commit drops the frame; no set pulse after release; slice keeps previously latched config.
REQ-039 First accepted beat possible on first rising edge after rst deasserts.

Structure
REQ-040 Package slicel_cfg_pkg holds the state enum and FRAME_BITS/field-offset functions of (S_XX_BASE, NUM_LUTS).
REQ-041 Sub-module cfg_shift_reg (FRAME_BITS-wide shift register with enable, serial in/out); FSM and counter in top.

Verification
REQ-042 Reset, then 143 beats of alternating 1,0 (first bit 1) -> luts_config_in[0]=1, comb_set at N+1, mem_set at N+2, cfg_done at N+3.
REQ-043 Frame with only bit 142 = 1 -> config_use_cc=1, all other outputs 0 after commit.
REQ-044 cfg_valid gapped 1-on/2-off through frame -> same result as REQ-042, cfg_ready constant 1 during SHIFT.
REQ-045 Abort after 70 beats, then full 143-beat frame -> exactly one comb_set/mem_set pair, outputs equal second frame.
REQ-046 rst pulsed during COMMIT_COMB -> mem_set never asserts, outputs 0, cfg_done 0.
REQ-047 Two back-to-back frames of 0xFF..FF then 0 -> cfg_out in second frame replays first frame bits in order, cfg_ready 0 for exactly 2 cycles between frames.

Source files
------------

// File: rtl/slicel_cfg_pkg.sv
// Shared types and frame-layout helpers for the slice configuration loader.
// Contents:
//   cfg_state_e  - loader FSM state encoding
//   cfg_size     - config bits per LUT for a given LUT input base
//   mux_lvls     - inter-LUT mux config width for a given LUT count
//   frame_bits   - total serial frame length
//   regs_off     - bit offset of the register init field inside the frame
package slicel_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT_COMB,
    ST_COMMIT_MEM,
    ST_DONE
  } cfg_state_e;

  function automatic int cfg_size(input int s_xx_base);
    return 2 * (2 ** s_xx_base) + 1;
  endfunction

  function automatic int mux_lvls(input int num_luts);
    return $clog2(num_luts);
  endfunction

  function automatic int frame_bits(input int cfg_sz, input int num_luts, input int mux_lv);
    return cfg_sz * num_luts + mux_lv + 2 * num_luts + 1;
  endfunction

  function automatic int regs_off(input int cfg_sz, input int num_luts, input int mux_lv);
    return cfg_sz * num_luts + mux_lv;
  endfunction

endpackage

// File: rtl/slicel_cfg_loader_shift_reg.sv
// cfg_shift_reg: serial-in shift register holding the configuration frame.
// New bits enter at the MSB; the bit leaving frame[0] is registered onto
// ser_out so the next slice in the chain sees the frame one pass later.
// Ports:
//   clk, rst  - clock, async active-high reset (clears frame and ser_out)
//   en        - shift one position this cycle
//   ser_in    - bit shifted into data[WIDTH-1]
//   ser_out   - registered copy of the bit shifted out of data[0]
//   data      - parallel frame contents
module cfg_shift_reg #(
  parameter int WIDTH = 143
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      ser_out <= 1'b0;
    end else if (en) begin
      data    <= {ser_in, data[WIDTH-1:1]};
      ser_out <= data[0];
    end
  end

endmodule

// File: rtl/slicel_cfg_loader.sv
// slicel_cfg_loader: serial configuration loader for one logic slice.
// Shifts a FRAME_BITS-long frame in LSB first, then issues comb_set and
// mem_set on consecutive cycles and holds cfg_done until the next frame.
// Ports:
//   clk, rst               - clock, async active-high reset
//   cfg_in, cfg_valid      - serial config beat
//   cfg_ready              - beat can be accepted (low only while committing)
//   cfg_abort              - drop the partial frame, return to idle
//   cfg_out                - daisy-chain output to the next slice
//   cfg_done               - last frame has been committed
//   luts_config_in, inter_lut_mux_config, regs_config_in, config_use_cc
//                          - frame fields, LSB field first
//   comb_set, mem_set      - one-cycle commit strobes to the slice
//
// state          | meaning
// ST_IDLE        | no frame in progress
// ST_SHIFT       | collecting frame bits
// ST_COMMIT_COMB | frame complete, slice latches comb config
// ST_COMMIT_MEM  | slice loads register initial state
// ST_DONE        | frame committed, waiting for next frame
module slicel_cfg_loader
  import slicel_cfg_pkg::*;
#(
  parameter int S_XX_BASE = 4,
  parameter int NUM_LUTS  = 4,
  parameter int CFG_SIZE  = cfg_size(S_XX_BASE),
  parameter int MUX_LVLS  = mux_lvls(NUM_LUTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_in,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic                         cfg_abort,
  output logic                         cfg_out,
  output logic                         cfg_done,
  output logic [CFG_SIZE*NUM_LUTS-1:0] luts_config_in,
  output logic [MUX_LVLS-1:0]          inter_lut_mux_config,
  output logic [2*NUM_LUTS-1:0]        regs_config_in,
  output logic                         config_use_cc,
  output logic                         comb_set,
  output logic                         mem_set
);

  localparam int FRAME_BITS = frame_bits(CFG_SIZE, NUM_LUTS, MUX_LVLS);
  localparam int LUT_BITS   = CFG_SIZE * NUM_LUTS;
  localparam int REGS_OFF   = regs_off(CFG_SIZE, NUM_LUTS, MUX_LVLS);
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic [FRAME_BITS-1:0] frame;

  // Ready is a decode of the state register only, so it never depends on
  // this cycle's inputs.
  assign cfg_ready = (state_q != ST_COMMIT_COMB) && (state_q != ST_COMMIT_MEM);
  assign accept    = cfg_valid && cfg_ready && !cfg_abort;

  cfg_shift_reg #(
    .WIDTH(FRAME_BITS)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .en     (accept),
    .ser_in (cfg_in),
    .ser_out(cfg_out),
    .data   (frame)
  );

  assign luts_config_in       = frame[LUT_BITS-1:0];
  assign inter_lut_mux_config = frame[REGS_OFF-1:LUT_BITS];
  assign regs_config_in       = frame[REGS_OFF+2*NUM_LUTS-1:REGS_OFF];
  assign config_use_cc        = frame[FRAME_BITS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    comb_set = 1'b0;
    mem_set  = 1'b0;
    cfg_done = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        cfg_done = (state_q == ST_DONE);
        if (cfg_abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          state_d = ST_SHIFT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (cfg_abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          if (cnt_q == LAST_CNT) begin
            state_d = ST_COMMIT_COMB;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      // Commit cannot be aborted once started; the slice must see both strobes.
      ST_COMMIT_COMB: begin
        comb_set = 1'b1;
        state_d  = ST_COMMIT_MEM;
      end
      ST_COMMIT_MEM: begin
        mem_set = 1'b1;
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_slicel_cfg_loader.sv
// Testbench for slicel_cfg_loader at default parameters (143-bit frame).
// A reference model keeps the history of accepted bits and a commit
// countdown; every cycle all DUT outputs are compared against it.
module tb_slicel_cfg_loader;

  localparam int FB = 143;

  logic clk = 1'b0;
  logic rst, cfg_in, cfg_valid, cfg_abort;
  logic cfg_ready, cfg_out, cfg_done, comb_set, mem_set, config_use_cc;
  logic [131:0] luts_config_in;
  logic [1:0]   inter_lut_mux_config;
  logic [7:0]   regs_config_in;

  slicel_cfg_loader dut (
    .clk                 (clk),
    .rst                 (rst),
    .cfg_in              (cfg_in),
    .cfg_valid           (cfg_valid),
    .cfg_ready           (cfg_ready),
    .cfg_abort           (cfg_abort),
    .cfg_out             (cfg_out),
    .cfg_done            (cfg_done),
    .luts_config_in      (luts_config_in),
    .inter_lut_mux_config(inter_lut_mux_config),
    .regs_config_in      (regs_config_in),
    .config_use_cc       (config_use_cc),
    .comb_set            (comb_set),
    .mem_set             (mem_set)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  bit hist[$];
  int beats = 0;
  int commit_left = 0;
  bit done_m = 1'b0;
  bit last_acc = 1'b0;
  int comb_cnt = 0;
  int mem_cnt = 0;

  task automatic chk(input string tag, input logic [FB-1:0] got, input logic [FB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [FB-1:0] exp_frame();
    logic [FB-1:0] f = '0;
    int n = hist.size();
    for (int i = 0; i < FB; i++) begin
      if (n - FB + i >= 0) f[i] = hist[n - FB + i];
    end
    return f;
  endfunction

  function automatic logic exp_out();
    int n = hist.size();
    return (n - FB - 1 >= 0) ? hist[n - FB - 1] : 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    beats = 0;
    commit_left = 0;
    done_m = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic b, input logic a);
    last_acc = 1'b0;
    if (commit_left > 0) begin
      commit_left--;
      if (commit_left == 0) done_m = 1'b1;
    end else if (a) begin
      beats = 0;
      done_m = 1'b0;
    end else if (v) begin
      last_acc = 1'b1;
      hist.push_back(b);
      if (hist.size() > FB + 1) void'(hist.pop_front());
      done_m = 1'b0;
      beats++;
      if (beats == FB) begin
        beats = 0;
        commit_left = 2;
      end
    end
  endtask

  task automatic check_all();
    chk("ready", FB'(cfg_ready), FB'(commit_left == 0));
    chk("comb_set", FB'(comb_set), FB'(commit_left == 2));
    chk("mem_set", FB'(mem_set), FB'(commit_left == 1));
    chk("cfg_done", FB'(cfg_done), FB'(done_m));
    chk("cfg_out", FB'(cfg_out), FB'(exp_out()));
    chk("frame", {config_use_cc, regs_config_in, inter_lut_mux_config, luts_config_in}, exp_frame());
    if (comb_set) comb_cnt++;
    if (mem_set) mem_cnt++;
  endtask

  // Called at a negedge; applies inputs for one rising edge, checks at next negedge.
  task automatic step(input logic v, input logic b, input logic a);
    cfg_valid = v;
    cfg_in    = b;
    cfg_abort = a;
    @(posedge clk);
    model_edge(v, b, a);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    cfg_valid = 1'b0;
    cfg_in    = 1'b0;
    cfg_abort = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [FB-1:0] fr, input int gap);
    for (int i = 0; i < FB; i++) begin
      step(1'b1, fr[i], 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  logic [FB-1:0] fr;
  int stall, ones, acc2;

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_in = 1'b0;
    cfg_abort = 1'b0;
    @(negedge clk);

    // alternating 1,0 starting with 1
    do_reset();
    for (int i = 0; i < FB; i++) fr[i] = (i % 2 == 0);
    comb_cnt = 0;
    mem_cnt = 0;
    send_frame(fr, 0);
    idle(3);
    chk("alt_lut0", FB'(luts_config_in[0]), FB'(1));
    chk("alt_pulses", FB'(comb_cnt + mem_cnt), FB'(2));

    // only the last frame bit set
    do_reset();
    fr = '0;
    fr[FB-1] = 1'b1;
    send_frame(fr, 0);
    idle(3);
    chk("cc_only_cc", FB'(config_use_cc), FB'(1));
    chk("cc_only_rest", FB'({regs_config_in, inter_lut_mux_config, luts_config_in}), '0);

    // gapped valid 1-on/2-off
    do_reset();
    for (int i = 0; i < FB; i++) fr[i] = (i % 2 == 0);
    send_frame(fr, 2);
    idle(3);
    chk("gap_lut0", FB'(luts_config_in[0]), FB'(1));

    // abort after 70 beats, then a full random frame
    do_reset();
    for (int i = 0; i < 70; i++) step(1'b1, 1'($urandom), 1'b0);
    step(1'b1, 1'b1, 1'b1);
    comb_cnt = 0;
    mem_cnt = 0;
    for (int i = 0; i < FB; i++) fr[i] = 1'($urandom);
    send_frame(fr, 0);
    idle(4);
    chk("abort_comb_cnt", FB'(comb_cnt), FB'(1));
    chk("abort_mem_cnt", FB'(mem_cnt), FB'(1));
    chk("abort_frame", {config_use_cc, regs_config_in, inter_lut_mux_config, luts_config_in}, fr);

    // reset during comb commit
    do_reset();
    for (int i = 0; i < FB; i++) step(1'b1, 1'b1, 1'b0);
    chk("rst_pre_comb", FB'(comb_set), FB'(1));
    mem_cnt = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    check_all();
    idle(4);
    chk("rst_mem_never", FB'(mem_cnt), FB'(0));
    chk("rst_done", FB'(cfg_done), FB'(0));

    // back-to-back all-ones then all-zeros frames
    do_reset();
    send_frame({FB{1'b1}}, 0);
    stall = 0;
    ones = 0;
    acc2 = 0;
    for (int k = 0; k < 10 && acc2 == 0; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (last_acc) begin
        acc2 = 1;
        if (cfg_out) ones++;
      end else begin
        stall++;
      end
    end
    chk("b2b_stall", FB'(stall), FB'(2));
    for (int k = 0; k < FB + 20 && acc2 < FB; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (last_acc) begin
        acc2++;
        if (cfg_out) ones++;
      end
    end
    chk("b2b_accepted", FB'(acc2), FB'(FB));
    chk("b2b_replay_ones", FB'(ones), FB'(FB));
    idle(3);

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 599) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
